// File: rtl/lfsr_4bit.sv
// Free-running Fibonacci LFSR, shift-left with feedback into the LSB.
// data_o is the state register itself; a zero state recovers to 1.
module lfsr_4bit #(
    parameter int          WIDTH = 4,
    parameter int unsigned SEED  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [WIDTH-1:0] data_o
);

    // One-hot bit for tap n, taps numbered 1..32.
    function automatic logic [31:0] tap(input int n);
        return 32'd1 << (n - 1);
    endfunction

    // Maximal-length XOR tap sets for every supported width.
    function automatic logic [31:0] tap_mask(input int w);
        logic [31:0] m;
        m = '0;
        case (w)
            2:  m = tap(2)  | tap(1);
            3:  m = tap(3)  | tap(2);
            4:  m = tap(4)  | tap(3);
            5:  m = tap(5)  | tap(3);
            6:  m = tap(6)  | tap(5);
            7:  m = tap(7)  | tap(6);
            8:  m = tap(8)  | tap(6)  | tap(5) | tap(4);
            9:  m = tap(9)  | tap(5);
            10: m = tap(10) | tap(7);
            11: m = tap(11) | tap(9);
            12: m = tap(12) | tap(6)  | tap(4) | tap(1);
            13: m = tap(13) | tap(4)  | tap(3) | tap(1);
            14: m = tap(14) | tap(5)  | tap(3) | tap(1);
            15: m = tap(15) | tap(14);
            16: m = tap(16) | tap(15) | tap(13) | tap(4);
            17: m = tap(17) | tap(14);
            18: m = tap(18) | tap(11);
            19: m = tap(19) | tap(6)  | tap(2) | tap(1);
            20: m = tap(20) | tap(17);
            21: m = tap(21) | tap(19);
            22: m = tap(22) | tap(21);
            23: m = tap(23) | tap(18);
            24: m = tap(24) | tap(23) | tap(22) | tap(17);
            25: m = tap(25) | tap(22);
            26: m = tap(26) | tap(6)  | tap(2) | tap(1);
            27: m = tap(27) | tap(5)  | tap(2) | tap(1);
            28: m = tap(28) | tap(25);
            29: m = tap(29) | tap(27);
            30: m = tap(30) | tap(6)  | tap(4) | tap(1);
            31: m = tap(31) | tap(28);
            32: m = tap(32) | tap(22) | tap(2) | tap(1);
            default: m = '0;
        endcase
        return m;
    endfunction

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_4bit: WIDTH %0d outside 2..32", WIDTH);
    end

    localparam logic [WIDTH-1:0] TAPS    = WIDTH'(tap_mask(WIDTH));
    localparam logic [WIDTH-1:0] SEED_W  = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_VAL = (SEED_W == '0) ? ONE : SEED_W;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nxt;
    logic             fb;

    // Next state: XOR of taps shifted in, or escape from the all-zero lock-up.
    always_comb begin
        fb  = ^(q & TAPS);
        nxt = {q[WIDTH-2:0], fb};
        if (q == '0) begin
            nxt = ONE;
        end
    end

    // State register with synchronous reset to the seed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q <= RST_VAL;
        end else begin
            q <= nxt;
        end
    end

    assign data_o = q;

endmodule

// File: tb/tb_lfsr_4bit.sv
// Bench for lfsr_4bit: reference table, random resets,
// lock-up recovery and a width/seed sweep.
module tb_lfsr_4bit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rst_p;
    logic [3:0] d4;
    logic [2:0] d3;
    logic [7:0] d8;

    lfsr_4bit dut4 (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_o (d4)
    );

    lfsr_4bit #(.WIDTH(3), .SEED(0)) dut3 (
        .clk_i  (clk),
        .rst_i  (rst_p),
        .data_o (d3)
    );

    lfsr_4bit #(.WIDTH(8), .SEED(32'hA5)) dut8 (
        .clk_i  (clk),
        .rst_i  (rst_p),
        .data_o (d8)
    );

    int total = 0;
    int bad   = 0;
    int idx   = 0;

    logic [3:0] ref4 [15] = '{
        4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
        4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8
    };

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; the model position follows the reset seen there.
    task automatic step();
        @(posedge clk);
        if (rst) idx = 0;
        else     idx = (idx + 1) % 15;
        #1;
    endtask

    // Polynomial step: double modulo 2^w, append parity of tapped bits.
    function automatic int poly_next(input int w, input int mask,
                                     input int s);
        int p;
        p = $countones(s & mask) % 2;
        return ((s * 2) + p) % (1 << w);
    endfunction

    initial begin
        int   v0;
        int   dup4;
        bit   seen4 [16];
        int   s3, s8, f3, f8, per3, per8;
        int   dup3, dup8, z3, z8, mis3, mis8;
        bit   seen3 [8];
        bit   seen8 [256];
        int   n;

        rst   = 1'b1;
        rst_p = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst4", d4, 4'h1);
            chk("rst3", d3, 3'h1);
            chk("rst8", d8, 8'hA5);
        end
        #2 rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            step();
            chk("run30", d4, ref4[idx]);
            chk("nonzero", d4 != 4'h0, 1);
        end

        v0   = d4;
        dup4 = 0;
        seen4[d4] = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (c < 15) begin
                if (seen4[d4]) dup4++;
                seen4[d4] = 1'b1;
            end
        end
        chk("period15", d4, v0);
        chk("dup4", dup4, 0);
        n = 0;
        for (int v = 0; v < 16; v++) n += int'(seen4[v]);
        chk("distinct4", n, 15);
        chk("zero_unseen", seen4[0], 0);

        for (int i = 0; i < 20 && d4 != 4'hD; i++) step();
        chk("find_1101", d4, 4'hD);
        rst = 1'b1;
        step();
        chk("midrst", d4, 4'h1);
        rst = 1'b0;
        step();
        chk("after_rst1", d4, 4'h2);
        step();
        chk("after_rst2", d4, 4'h4);

        for (int i = 0; i < 200; i++) begin
            rst = ($urandom_range(0, 11) == 0);
            step();
            chk("rand", d4, ref4[idx]);
        end
        rst = 1'b0;

        force dut4.q = 4'h0;
        #1 release dut4.q;
        #1 chk("forced0", d4, 4'h0);
        step();
        idx = 0;
        chk("lockup", d4, 4'h1);
        step();
        chk("resume1", d4, ref4[idx]);
        step();
        chk("resume2", d4, ref4[idx]);

        rst_p = 1'b1;
        step();
        chk("sweep_rst3", d3, 3'h1);
        chk("sweep_rst8", d8, 8'hA5);
        #2 rst_p = 1'b0;
        s3 = 1;
        s8 = 'hA5;
        f3 = d3;
        f8 = d8;
        per3 = 0; per8 = 0;
        dup3 = 0; dup8 = 0;
        z3 = 0;   z8 = 0;
        mis3 = 0; mis8 = 0;
        seen3[d3] = 1'b1;
        seen8[d8] = 1'b1;
        for (int c = 1; c <= 260; c++) begin
            step();
            s3 = poly_next(3, 'h6, s3);
            s8 = poly_next(8, 'hB8, s8);
            if (int'(d3) != s3) mis3++;
            if (int'(d8) != s8) mis8++;
            if (d3 == 3'h0) z3++;
            if (d8 == 8'h0) z8++;
            if (per3 == 0) begin
                if (int'(d3) == f3) per3 = c;
                else begin
                    if (seen3[d3]) dup3++;
                    seen3[d3] = 1'b1;
                end
            end
            if (per8 == 0) begin
                if (int'(d8) == f8) per8 = c;
                else begin
                    if (seen8[d8]) dup8++;
                    seen8[d8] = 1'b1;
                end
            end
        end
        chk("w3_period", per3, 7);
        chk("w3_seq", mis3, 0);
        chk("w3_dup", dup3, 0);
        chk("w3_zero", z3, 0);
        chk("w8_period", per8, 255);
        chk("w8_seq", mis8, 0);
        chk("w8_dup", dup8, 0);
        chk("w8_zero", z8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
